// File: rtl/counter_stim_gen.sv
// Stimulus generator for an up/down counter: start launches UP, HOLD, DOWN and
// pseudo-random phases. Define CNT_STIM_WRAP_EN to add a full-range WRAP phase.
module counter_stim_gen #(
  parameter int          N         = 8,
  parameter int          UP_LEN    = 10,
  parameter int          HOLD_LEN  = 3,
  parameter int          DOWN_LEN  = 10,
  parameter int          RAND_LEN  = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stall,
  output logic        en,
  output logic        up_dn,
  output logic        busy,
  output logic        done,
  output logic [2:0]  phase,
  output logic [15:0] en_cnt
);

`ifdef CNT_STIM_WRAP_EN
  localparam int STEP_W   = (N + 2 > 16) ? N + 2 : 16;
  localparam int WRAP_LEN = 2 ** N + 2;
`else
  localparam int STEP_W   = 16;
`endif
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;

  // 2**N must stay representable in a 32-bit int
  if (N < 1 || N > 30) begin : g_bad_n
    $error("counter_stim_gen: N out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_UP   = 3'd1,
    S_HOLD = 3'd2,
    S_DOWN = 3'd3,
    S_RAND = 3'd4,
`ifdef CNT_STIM_WRAP_EN
    S_WRAP = 3'd6,
`endif
    S_DONE = 3'd5
  } state_t;

  state_t             state_q, state_d, nxt;
  logic [STEP_W-1:0]  step_q, step_d, len_last;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [15:0]        en_cnt_q, en_cnt_d;
  logic               adv;

  // Successor chains skip zero-length phases inside a single transition.
  function automatic state_t after_wrap();
    return (RAND_LEN != 0) ? S_RAND : S_DONE;
  endfunction

  function automatic state_t after_down();
`ifdef CNT_STIM_WRAP_EN
    return S_WRAP;
`else
    return after_wrap();
`endif
  endfunction

  function automatic state_t after_hold();
    return (DOWN_LEN != 0) ? S_DOWN : after_down();
  endfunction

  function automatic state_t after_up();
    return (HOLD_LEN != 0) ? S_HOLD : after_hold();
  endfunction

  function automatic state_t from_idle();
    return (UP_LEN != 0) ? S_UP : after_up();
  endfunction

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    lfsr_d   = lfsr_q;
    en       = 1'b0;
    up_dn    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    adv      = 1'b0;
    len_last = '0;
    nxt      = S_IDLE;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = from_idle();
          step_d  = '0;
          lfsr_d  = SEED;
        end
      end
      S_UP: begin
        busy     = 1'b1;
        en       = !stall;
        adv      = !stall;
        len_last = STEP_W'(UP_LEN - 1);
        nxt      = after_up();
      end
      S_HOLD: begin
        busy     = 1'b1;
        adv      = 1'b1;
        len_last = STEP_W'(HOLD_LEN - 1);
        nxt      = after_hold();
      end
      S_DOWN: begin
        busy     = 1'b1;
        en       = !stall;
        up_dn    = 1'b1;
        adv      = !stall;
        len_last = STEP_W'(DOWN_LEN - 1);
        nxt      = after_down();
      end
`ifdef CNT_STIM_WRAP_EN
      S_WRAP: begin
        busy     = 1'b1;
        en       = !stall;
        up_dn    = 1'b1;
        adv      = !stall;
        len_last = STEP_W'(WRAP_LEN - 1);
        nxt      = after_wrap();
      end
`endif
      S_RAND: begin
        busy     = 1'b1;
        en       = lfsr_q[0] & !stall;
        up_dn    = lfsr_q[1];
        adv      = !stall;
        len_last = STEP_W'(RAND_LEN - 1);
        nxt      = S_DONE;
        // x^16+x^14+x^13+x^11+1, shifted left with feedback into bit 0
        if (!stall) lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (adv) begin
      if (step_q == len_last) begin
        step_d  = '0;
        state_d = nxt;
      end else begin
        step_d = step_q + STEP_W'(1);
      end
    end

    if (state_q == S_IDLE && start) en_cnt_d = 16'h0;
    else                            en_cnt_d = en_cnt_q + 16'(en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      step_q   <= '0;
      lfsr_q   <= SEED;
      en_cnt_q <= 16'h0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      lfsr_q   <= lfsr_d;
      en_cnt_q <= en_cnt_d;
    end
  end

  assign phase  = state_q;
  assign en_cnt = en_cnt_q;

endmodule

// File: tb/tb_counter_stim_gen.sv
// Randomized bench for counter_stim_gen: a default-length instance and a
// UP_LEN=0/HOLD_LEN=0 instance, both checked every cycle against a phase-list model.
module tb_counter_stim_gen;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, stall = 1'b0;
  logic [1:0]  en, up_dn, busy, done;
  logic [2:0]  ph [2];
  logic [15:0] cnt [2];
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  counter_stim_gen dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .en(en[0]), .up_dn(up_dn[0]), .busy(busy[0]), .done(done[0]),
    .phase(ph[0]), .en_cnt(cnt[0])
  );

  counter_stim_gen #(.UP_LEN(0), .HOLD_LEN(0), .DOWN_LEN(4), .RAND_LEN(5)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .en(en[1]), .up_dn(up_dn[1]), .busy(busy[1]), .done(done[1]),
    .phase(ph[1]), .en_cnt(cnt[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase list UP,HOLD,DOWN,RAND (index 0..3), DONE=4, idle=-1.
  int          LEN [2][4] = '{'{10, 3, 10, 16}, '{0, 0, 4, 5}};
  int          idx [2];
  int          pos [2];
  logic [15:0] lfsr_m [2];
  logic [15:0] encnt_m [2];

  function automatic int nxt(input int i, input int k);
    for (int j = k + 1; j < 4; j++) if (LEN[i][j] > 0) return j;
    return 4;
  endfunction

  // {en, up_dn, busy, done, phase}
  function automatic logic [6:0] expv(input int i, input logic st);
    case (idx[i])
      0:       return {!st, 1'b0, 1'b1, 1'b0, 3'd1};
      1:       return {1'b0, 1'b0, 1'b1, 1'b0, 3'd2};
      2:       return {!st, 1'b1, 1'b1, 1'b0, 3'd3};
      3:       return {lfsr_m[i][0] & !st, lfsr_m[i][1], 1'b1, 1'b0, 3'd4};
      4:       return {1'b0, 1'b0, 1'b0, 1'b1, 3'd5};
      default: return 7'd0;
    endcase
  endfunction

  function automatic logic exp_en(input int i, input logic st);
    logic [6:0] v;
    v = expv(i, st);
    return v[6];
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        idx[i] <= -1; pos[i] <= 0; lfsr_m[i] <= 16'hACE1; encnt_m[i] <= 16'h0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (idx[i] == -1) begin
          if (start) begin
            idx[i] <= nxt(i, -1); pos[i] <= 0; encnt_m[i] <= 16'h0; lfsr_m[i] <= 16'hACE1;
          end
        end else if (idx[i] == 4) begin
          idx[i] <= -1;
        end else begin
          if (exp_en(i, stall)) encnt_m[i] <= encnt_m[i] + 16'h1;
          if (idx[i] == 1 || !stall) begin
            if (idx[i] == 3) lfsr_m[i] <= {lfsr_m[i][14:0], ^(lfsr_m[i] & 16'hB400)};
            if (pos[i] + 1 == LEN[i][idx[i]]) begin
              idx[i] <= nxt(i, idx[i]); pos[i] <= 0;
            end else begin
              pos[i] <= pos[i] + 1;
            end
          end
        end
      end
    end
  end

  logic       seen12 = 1'b0;
  logic [7:0] ut = 8'h0;

  always @(negedge clk) begin : compare
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("outs%0d", i), {25'h0, en[i], up_dn[i], busy[i], done[i], ph[i]}, {25'h0, expv(i, stall)});
      chk($sformatf("en_cnt%0d", i), {16'h0, cnt[i]}, {16'h0, encnt_m[i]});
    end
    if (ph[1] == 3'd1 || ph[1] == 3'd2) seen12 <= 1'b1;
  end

  // counter under test driven by dut0
  always @(posedge clk) if (en[0]) ut <= up_dn[0] ? ut - 8'h1 : ut + 8'h1;

  logic [1:0] tr1 [41];
  logic [1:0] tr2 [41];

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit ok;
    @(negedge clk);
    chk("rst_outs", {en[0], up_dn[0], busy[0], done[0], ph[0]}, 32'h0);
    chk("rst_en_cnt", cnt[0], 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Run 1: defaults, no stall, start sampled at cycle 5
    pulse_start();
    for (int c = 0; c < 41; c++) begin
      @(negedge clk);
      tr1[c] = {en[0], up_dn[0]};
      if (c == 0)  chk("dut1_first_phase", ph[1], 32'd3);
      if (c == 9)  chk("up_last", {en[0], up_dn[0], ph[0]}, {27'h0, 2'b10, 3'd1});
      if (c == 10) begin chk("hold_phase", ph[0], 32'd2); chk("hold_en_cnt", cnt[0], 32'd10); end
      if (c == 13) chk("down_first", {en[0], up_dn[0], ph[0]}, {27'h0, 2'b11, 3'd3});
      if (c == 23) begin
        chk("rand_phase", ph[0], 32'd4);
        chk("rand_en_cnt", cnt[0], 32'd20);
        chk("counter_zero", ut, 32'd0);
        chk("rand0", {en[0], up_dn[0]}, 32'b10);
      end
      if (c == 24) chk("rand1", {en[0], up_dn[0]}, 32'b11);
      if (c == 25) chk("rand2", {en[0], up_dn[0]}, 32'b11);
      if (c == 39) chk("done", {done[0], busy[0], ph[0]}, {27'h0, 2'b10, 3'd5});
      if (c == 40) chk("back_idle", {done[0], busy[0], ph[0]}, 32'h0);
    end

    // Run 2: 4-cycle stall in UP, start pulse in DOWN, random stall in RAND
    pulse_start();
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (c == 13) chk("stall_up_len", ph[0], 32'd1);
      if (c == 14) begin chk("stall_hold", ph[0], 32'd2); chk("stall_en_cnt", cnt[0], 32'd10); end
      if (c > 6 && ph[0] == 3'd0) begin ok = 1'b1; break; end
      @(posedge clk); #1;
      stall = (c + 1 >= 3 && c + 1 <= 6) || (ph[0] == 3'd4 && $urandom_range(0, 3) == 0);
      start = (c + 1 == 20);
    end
    chk("run2_finished", ok, 1'b1);
    stall = 1'b0; start = 1'b0;

    // Run 3: random start and stall, including starts while busy
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 3) == 0);
    end
    start = 1'b0; stall = 1'b0;

    // Run 4: asynchronous reset mid-DOWN, then identical replay
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (ph[0] == 3'd0) begin ok = 1'b1; break; end
    end
    chk("idle_before_reset", ok, 1'b1);
    pulse_start();
    repeat (15) @(negedge clk);
    chk("mid_down", ph[0], 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst0", {en[0], busy[0], ph[0]}, 32'h0);
    chk("async_rst1", {en[1], busy[1], ph[1]}, 32'h0);
    chk("async_rst_cnt", cnt[0], 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    pulse_start();
    for (int c = 0; c < 41; c++) begin
      @(negedge clk);
      tr2[c] = {en[0], up_dn[0]};
      chk($sformatf("replay%0d", c), tr2[c], tr1[c]);
    end

    chk("dut1_no_phase12", seen12, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/counter_stim_gen.md
Name: counter_stim_gen

Overview:
- Stimulus generator that drives the `en`/`up_dn` control pair into the N-bit up/down counter under test.
- It is the producing end of the interface that the counter checker consumes.
- A start pulse launches a fixed, parameterised sequence of phases: count-up run, hold, count-down run, pseudo-random run.
- Status outputs let the bench align checking with each phase.

Parameters:
- N, 8: width of the counter under test; only used by the optional wrap phase.
- UP_LEN, 10: number of enabled increment cycles in the UP phase (0 = phase skipped).
- HOLD_LEN, 3: number of idle cycles in the HOLD phase (0 = skipped).
- DOWN_LEN, 10: number of enabled decrement cycles in the DOWN phase (0 = skipped).
- RAND_LEN, 16: number of non-stalled cycles in the RAND phase (0 = skipped).
- LFSR_SEED, 16'hACE1: LFSR reset/start value; a value of 0 is replaced by 16'hACE1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  launches a sequence when sampled high in IDLE.
- stall  input  1  suspends generation in UP/DOWN/RAND (and WRAP).
- en  output  1  counter enable to DUT.
- up_dn  output  1  direction to DUT; 1 = decrement, 0 = increment.
- busy  output  1  high while a sequence is running.
- done  output  1  one-cycle pulse at sequence end.
- phase  output  3  current state code.
- en_cnt  output  16  number of en=1 cycles issued since the last start; wraps at 2^16.

Behaviour:
- State encoding: IDLE=0, UP=1, HOLD=2, DOWN=3, RAND=4, DONE=5, WRAP=6 (optional feature only).
- Registers: state, 16-bit step counter, 16-bit LFSR, en_cnt.
- en, up_dn, busy and done are combinational from registered state, LFSR and stall.
- Reset (asynchronous):
  - state=IDLE, step=0, LFSR=seed, en_cnt=0.
  - All outputs 0 immediately, including mid-sequence.
- IDLE:
  - en=0, up_dn=0.
  - start=1 at edge k: enter the first phase with nonzero length, or DONE if all lengths are 0.
  - On that same edge: clear en_cnt and step, reload LFSR with seed.
  - The first en=1 is visible in the cycle after edge k.
- UP: en=!stall, up_dn=0.
  - step advances only on non-stalled cycles.
  - On a non-stalled cycle with step==UP_LEN-1: step=0, go to next nonzero phase.
  - Result: exactly UP_LEN enabled cycles.
- HOLD: en=0, up_dn=0.
  - step advances every cycle; stall ignored.
  - Leave after HOLD_LEN cycles.
- DOWN: en=!stall, up_dn=1.
  - Same counting rule as UP, using DOWN_LEN.
- RAND: en=LFSR[0] & !stall, up_dn=LFSR[1] (driven even when en=0).
  - LFSR and step advance only on non-stalled cycles.
  - Leave after RAND_LEN non-stalled cycles.
  - LFSR: Fibonacci, polynomial x^16+x^14+x^13+x^11+1; shift left, feedback into bit 0 = b15^b13^b12^b10.
- DONE: done=1 and en=0 for exactly one cycle, then IDLE unconditionally.
- busy=1 in UP, HOLD, DOWN, RAND and WRAP; 0 in IDLE and DONE.
- Boundary and simultaneous events:
  - start while busy or in DONE is ignored.
  - Length-0 phases are skipped in the same transition; the phase code is never visible.
  - en_cnt increments on every cycle where en=1.
  - stall asserted on the final cycle of a phase delays the exit.

Optional Feature:
- Macro: CNT_STIM_WRAP_EN.
- Defined:
  - WRAP phase (code 6) is inserted between DOWN and RAND.
  - Drives en=!stall, up_dn=1 for 2**N+2 non-stalled cycles.
  - This forces the counter under test through underflow and a full wrap-around plus 2.
  - Step counter is widened to hold 2**N+2 if that exceeds 16 bits.
- Undefined:
  - DOWN goes directly to RAND; phase never equals 6.
  - No extra logic is present.

Test Plan:
- Reset, start pulse at cycle 5, defaults, stall=0 -> en=1/up_dn=0 for 10 cycles, en=0 for 3, en=1/up_dn=1 for 10; the counter returns to 0 before RAND.
- stall=1 for 4 cycles in mid-UP -> en=0 during stall; UP lasts 14 cycles; en_cnt=10 on entering HOLD.
- RAND phase -> en/up_dn match a bench LFSR model (seed 16'hACE1) over 16 cycles; done high exactly one cycle later; busy falls with done; phase returns to 0.
- start pulsed again during DOWN -> ignored; sequence timing and en_cnt unchanged.
- rst_n low mid-DOWN -> en, busy, phase = 0 without a clock edge; next start reproduces an identical en/up_dn trace.
- Overrides UP_LEN=0, HOLD_LEN=0 -> phase goes 0->3 directly on start; no code 1 or 2 ever observed.
